// File: rtl/imem_pkg.sv
// Shared types and defaults for the instruction memory fetch controller.
package imem_pkg;

  localparam int unsigned INSTR_W_DEF = 19;
  localparam int unsigned ADDR_W_DEF  = 12;
  localparam int unsigned DEPTH_DEF   = 4096;

  typedef enum logic {CLEAR, RUN} imem_state_t;

  localparam logic [INSTR_W_DEF-1:0] NOP_INSTR = '0;

endpackage

// File: rtl/imem_sram_1r1w.sv
// Synchronous 1-read/1-write array, registered read data, read-before-write.
module imem_sram_1r1w #(
  parameter int unsigned W      = 19,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DEPTH  = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [W-1:0]      rdata_o,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [W-1:0]      wdata_i
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rdata_q;

  // Only the read register is reset; the array contents are left to the clear sequencer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction memory with registered fetch, program-load port and clear sequencer.
// Optional stored parity bit per word when IMEM_PARITY_EN is defined.
module imem_fetch_ctrl
  import imem_pkg::*;
#(
  parameter int unsigned INSTR_W = INSTR_W_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DEPTH   = DEPTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  output logic               mem_ready,
  input  logic               fetch_req,
  input  logic [ADDR_W-1:0]  fetch_addr,
  output logic               fetch_valid,
  output logic [INSTR_W-1:0] instruction,
  output logic               fetch_err,
  input  logic               ld_we,
  input  logic [ADDR_W-1:0]  ld_addr,
  input  logic [INSTR_W-1:0] ld_data,
  input  logic               ld_par_inv,
  output logic               ld_ack,
  output logic               parity_err
);

`ifdef IMEM_PARITY_EN
  localparam int unsigned MEM_W = INSTR_W + 1;
`else
  localparam int unsigned MEM_W = INSTR_W;
`endif

  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  imem_state_t       state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              valid_q, oor_q, ack_q;

  logic              fetch_acc, fetch_oor, rd_en, ld_acc;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [MEM_W-1:0]  wr_data, ld_word;
  logic [MEM_W-1:0]  rd_data;
  logic              fetch_in_range, ld_in_range;

  assign fetch_in_range = ({1'b0, fetch_addr} < DEPTH_L);
  assign ld_in_range    = ({1'b0, ld_addr} < DEPTH_L);

`ifdef IMEM_PARITY_EN
  assign ld_word = {(^ld_data) ^ ld_par_inv, ld_data};
`else
  logic unused_par_inv;
  assign unused_par_inv = ld_par_inv;
  assign ld_word = ld_data;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    fetch_acc = 1'b0;
    fetch_oor = 1'b0;
    rd_en     = 1'b0;
    ld_acc    = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = ld_addr;
    wr_data   = ld_word;
    unique case (state_q)
      CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = cnt_q;
        wr_data = '0;
        if (cnt_q == LAST) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        fetch_acc = fetch_req;
        fetch_oor = fetch_req && !fetch_in_range;
        rd_en     = fetch_req && fetch_in_range;
        ld_acc    = ld_we && ld_in_range;
        wr_en     = ld_acc;
      end
      default: state_d = CLEAR;
    endcase
  end

  // oor_q is only updated on an accepted fetch so instruction holds between fetches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      oor_q   <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= fetch_acc;
      ack_q   <= ld_acc;
      if (fetch_acc) begin
        oor_q <= fetch_oor;
      end
    end
  end

  imem_sram_1r1w #(
    .W      (MEM_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_sram (
    .clk     (clk),
    .rst     (rst),
    .re_i    (rd_en),
    .raddr_i (fetch_addr),
    .rdata_o (rd_data),
    .we_i    (wr_en),
    .waddr_i (wr_addr),
    .wdata_i (wr_data)
  );

  assign mem_ready   = (state_q == RUN);
  assign fetch_valid = valid_q;
  assign fetch_err   = valid_q & oor_q;
  assign ld_ack      = ack_q;
  assign instruction = oor_q ? INSTR_W'(NOP_INSTR) : rd_data[INSTR_W-1:0];

`ifdef IMEM_PARITY_EN
  assign parity_err = valid_q & ~oor_q & ((^rd_data[INSTR_W-1:0]) != rd_data[INSTR_W]);
`else
  assign parity_err = 1'b0;
`endif

endmodule
